// File: rtl/fifo_reader.sv
// ============================================================================
// Module      : fifo_reader
// Description : Drains a registered-output FIFO into a valid/ready stream
//               through a 2-entry skid buffer, tagging BURST_LEN-word bursts.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int BURST_LEN  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fifo_empty,
    output logic                  fifo_read_en,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic [7:0]            burst_idx
);

    localparam logic [7:0] c_LAST_IDX = 8'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic                  r_inflight;
    logic [DATA_WIDTH-1:0] r_buf0;
    logic [DATA_WIDTH-1:0] r_buf1;
    logic [7:0]            r_burst_idx;
    logic                  w_pop;
    logic                  w_capture;
    logic [1:0]            w_occ;
    logic [2:0]            w_demand;

    assign m_valid   = (r_state != S_EMPTY);
    assign m_data    = r_buf0;
    assign burst_idx = r_burst_idx;
    assign m_last    = m_valid & (r_burst_idx == c_LAST_IDX);
    assign w_pop     = m_valid & m_ready;
    assign w_capture = r_inflight;

    // Request a word only if it is guaranteed a slot when it lands; pop never
    // exceeds occupancy, so the subtraction cannot underflow.
    always_comb begin
        w_occ = 2'd0;
        case (r_state)
            S_ONE:   w_occ = 2'd1;
            S_TWO:   w_occ = 2'd2;
            default: w_occ = 2'd0;
        endcase
        w_demand     = {1'b0, w_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
        fifo_read_en = ~reset & ~fifo_empty & (w_demand < 3'd2);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_EMPTY: if (w_capture) w_state_next = S_ONE;
            S_ONE: begin
                if (w_capture && !w_pop)      w_state_next = S_TWO;
                else if (!w_capture && w_pop) w_state_next = S_EMPTY;
            end
            S_TWO:   if (w_pop && !w_capture) w_state_next = S_ONE;
            default: w_state_next = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_inflight  <= 1'b0;
            r_buf0      <= '0;
            r_buf1      <= '0;
            r_burst_idx <= 8'd0;
        end else begin
            r_inflight <= fifo_read_en;

            // r_buf0 always holds the oldest word; r_buf1 the younger one.
            if (w_capture) begin
                case (r_state)
                    S_EMPTY: r_buf0 <= fifo_data;
                    S_ONE: begin
                        if (w_pop) r_buf0 <= fifo_data;
                        else       r_buf1 <= fifo_data;
                    end
                    S_TWO: begin
                        r_buf0 <= r_buf1;
                        r_buf1 <= fifo_data;
                    end
                    default: r_buf0 <= fifo_data;
                endcase
            end else if (w_pop && r_state == S_TWO) begin
                r_buf0 <= r_buf1;
            end

            if (w_pop) begin
                if (r_burst_idx == c_LAST_IDX) r_burst_idx <= 8'd0;
                else                           r_burst_idx <= r_burst_idx + 8'd1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fifo_reader.sv
// ============================================================================
// Module      : tb_fifo_reader
// Description : Scoreboard bench for fifo_reader with a registered FIFO model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_reader;

    localparam int DATA_WIDTH = 8;
    localparam int BURST_LEN  = 4;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic                  fifo_empty = 1'b1;
    logic                  fifo_read_en;
    logic [DATA_WIDTH-1:0] fifo_data = '0;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_valid;
    logic                  m_ready = 1'b0;
    logic                  m_last;
    logic [7:0]            burst_idx;

    int checks = 0;
    int failures = 0;

    logic [DATA_WIDTH-1:0] src[$];
    logic [DATA_WIDTH-1:0] exp_q[$];
    int  exp_idx = 0;
    int  rd_count = 0;
    int  delivered = 0;
    bit  rand_en = 1'b0;

    fifo_reader #(
        .DATA_WIDTH(DATA_WIDTH),
        .BURST_LEN (BURST_LEN)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .fifo_empty  (fifo_empty),
        .fifo_read_en(fifo_read_en),
        .fifo_data   (fifo_data),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_last      (m_last),
        .burst_idx   (burst_idx)
    );

    always #5 clk = ~clk;

    // Registered-output FIFO: an accepted read returns data the next cycle.
    always @(posedge clk) begin
        logic [DATA_WIDTH-1:0] w;
        if (fifo_read_en && !fifo_empty && src.size() > 0) begin
            w = src.pop_front();
            fifo_data <= w;
            exp_q.push_back(w);
            rd_count++;
        end
        fifo_empty <= (src.size() == 0) || (rand_en && ($urandom_range(0, 3) == 0));
    end

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (!reset) begin
            checks++;
            if (fifo_read_en && fifo_empty) begin
                failures++;
                $display("FAIL read_en_while_empty: read_en=%0b empty=%0b required read_en=0", fifo_read_en, fifo_empty);
            end
            if (m_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_valid: m_valid=1 data=%02h required no word pending", m_data);
                end else begin
                    checks++;
                    if (m_data !== exp_q[0]) begin
                        failures++;
                        $display("FAIL sb_data: got %02h required %02h", m_data, exp_q[0]);
                    end
                    checks++;
                    if (burst_idx !== 8'(exp_idx)) begin
                        failures++;
                        $display("FAIL sb_burst_idx: got %0d required %0d", burst_idx, exp_idx);
                    end
                    checks++;
                    if (m_last !== (exp_idx == BURST_LEN - 1)) begin
                        failures++;
                        $display("FAIL sb_last: got %0b required %0b", m_last, (exp_idx == BURST_LEN - 1));
                    end
                    if (m_ready) begin
                        void'(exp_q.pop_front());
                        exp_idx = (exp_idx == BURST_LEN - 1) ? 0 : exp_idx + 1;
                        delivered++;
                    end
                end
            end
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        src.delete();
        exp_q.delete();
        exp_idx   = 0;
        rd_count  = 0;
        delivered = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic wait_valid(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (m_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        src.push_back(8'h5A);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (fifo_read_en !== 1'b0) begin failures++; $display("FAIL rst_read_en: got %0b required 0", fifo_read_en); end
        checks++;
        if (m_valid !== 1'b0) begin failures++; $display("FAIL rst_m_valid: got %0b required 0", m_valid); end
        checks++;
        if (m_last !== 1'b0) begin failures++; $display("FAIL rst_m_last: got %0b required 0", m_last); end
        checks++;
        if (m_data !== 8'h00) begin failures++; $display("FAIL rst_m_data: got %02h required 00", m_data); end
        checks++;
        if (burst_idx !== 8'd0) begin failures++; $display("FAIL rst_burst_idx: got %0d required 0", burst_idx); end
        do_reset();
    endtask

    task automatic test_single();
        bit ok;
        m_ready = 1'b1;
        src.push_back(8'hA5);
        @(posedge clk); #1;
        checks++;
        if (fifo_read_en !== 1'b1) begin failures++; $display("FAIL single_read_en: got %0b required 1", fifo_read_en); end
        @(posedge clk); #1;
        checks++;
        if (fifo_read_en !== 1'b0 || m_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_gap: read_en=%0b m_valid=%0b required 0 0", fifo_read_en, m_valid);
        end
        @(posedge clk); #1;
        checks++;
        if (m_valid !== 1'b1 || m_data !== 8'hA5 || burst_idx !== 8'd0 || m_last !== 1'b0) begin
            failures++;
            $display("FAIL single_latency: valid=%0b data=%02h idx=%0d last=%0b required 1 a5 0 0", m_valid, m_data, burst_idx, m_last);
        end
        wait_valid(1, ok);
        repeat (2) @(posedge clk);
    endtask

    task automatic test_stream();
        bit ok;
        int run;
        do_reset();
        m_ready = 1'b1;
        for (int i = 1; i <= 8; i++) src.push_back(8'(i));
        wait_valid(10, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL stream_start: m_valid never rose required 1"); end
        run = ok ? 1 : 0;
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            if (m_valid) run++;
        end
        checks++;
        if (run != 8) begin failures++; $display("FAIL stream_throughput: got %0d valid cycles required 8", run); end
        repeat (3) @(posedge clk); #1;
        checks++;
        if (delivered != 8) begin failures++; $display("FAIL stream_count: got %0d required 8", delivered); end
    endtask

    task automatic test_backpressure();
        bit done;
        do_reset();
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) src.push_back(8'h10 + 8'(i));
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (rd_count != 2) begin failures++; $display("FAIL bp_reads: got %0d required 2", rd_count); end
        checks++;
        if (fifo_read_en !== 1'b0 || m_valid !== 1'b1) begin
            failures++;
            $display("FAIL bp_hold: read_en=%0b m_valid=%0b required 0 1", fifo_read_en, m_valid);
        end
        @(posedge clk); #1;
        checks++;
        if (m_data !== 8'h10) begin failures++; $display("FAIL bp_stable: got %02h required 10", m_data); end
        m_ready = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 50 && !done; i++) begin
            @(posedge clk); #1;
            done = (delivered == 5);
        end
        checks++;
        if (!done || rd_count != 5 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL bp_drain: delivered=%0d reads=%0d pending=%0d required 5 5 0", delivered, rd_count, exp_q.size());
        end
    endtask

    task automatic test_empty();
        bit saw_rd;
        bit saw_valid;
        do_reset();
        m_ready = 1'b1;
        saw_rd = 1'b0;
        saw_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (fifo_read_en) saw_rd = 1'b1;
            if (m_valid) saw_valid = 1'b1;
        end
        checks++;
        if (saw_rd) begin failures++; $display("FAIL empty_read_en: got 1 required never"); end
        checks++;
        if (saw_valid) begin failures++; $display("FAIL empty_valid: got 1 required never"); end
    endtask

    task automatic test_reset_mid_burst();
        bit ok;
        do_reset();
        m_ready = 1'b0;
        for (int i = 0; i < 6; i++) src.push_back(8'h30 + 8'(i));
        repeat (6) @(posedge clk);
        #1 m_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 m_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (m_valid !== 1'b1 || burst_idx !== 8'd2 || m_data !== 8'h32) begin
            failures++;
            $display("FAIL mid_pre: valid=%0b idx=%0d data=%02h required 1 2 32", m_valid, burst_idx, m_data);
        end
        #1 reset = 1'b1;
        src.delete();
        exp_q.delete();
        exp_idx = 0;
        delivered = 0;
        #1;
        checks++;
        if (m_valid !== 1'b0 || burst_idx !== 8'd0 || m_last !== 1'b0) begin
            failures++;
            $display("FAIL mid_async: valid=%0b idx=%0d last=%0b required 0 0 0", m_valid, burst_idx, m_last);
        end
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        m_ready = 1'b1;
        src.push_back(8'h77);
        wait_valid(10, ok);
        checks++;
        if (!ok || m_data !== 8'h77 || burst_idx !== 8'd0) begin
            failures++;
            $display("FAIL mid_resume: ok=%0b data=%02h idx=%0d required 1 77 0", ok, m_data, burst_idx);
        end
        repeat (3) @(posedge clk);
    endtask

    task automatic test_random();
        int pushed;
        bit done;
        do_reset();
        rand_en = 1'b1;
        pushed = 0;
        for (int i = 0; i < 10000; i++) begin
            @(posedge clk); #1;
            m_ready = 1'($urandom_range(0, 1));
            if (src.size() < 4 && $urandom_range(0, 2) != 0) begin
                src.push_back(8'(pushed));
                pushed++;
            end
        end
        rand_en = 1'b0;
        m_ready = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(posedge clk); #1;
            done = (src.size() == 0 && exp_q.size() == 0 && !m_valid);
        end
        checks++;
        if (!done || delivered != pushed) begin
            failures++;
            $display("FAIL random_drain: delivered=%0d required %0d (done=%0b)", delivered, pushed, done);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_stream();
        test_backpressure();
        test_empty();
        test_reset_mid_burst();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
